viterbi_frame_scheduler: RTL and testbench
==========================================

# viterbi_frame_scheduler

Frame-granular round-robin arbiter that shares one Viterbi decoder input stream between two soft-symbol AXI4-Stream sources, such as two channel input buffers. It grants one source for a full frame of `cfg_frame_len` beats, inserts `tlast` on the final beat, tags each beat with the source ID, and counts completed frames. It sits between the input buffers and the decoder's slave stream port; the frame length and enable come from the AXI-Lite register bank of the buffer IP.

## Interface
- `DATA_WIDTH`, 16, soft-symbol pair width per beat.
- `LEN_WIDTH`, 12, width of the frame-length field (maximum frame 4095 beats).
- `aclk`  in  1  single clock for all logic.
- `areset`  in  1  synchronous, active-high reset.
- `cfg_enable`  in  1  permits new grants; sampled only in IDLE.
- `cfg_frame_len`  in  LEN_WIDTH  beats per frame; latched at grant.
- `s0_axis_tdata` / `s1_axis_tdata`  in  DATA_WIDTH  source symbols.
- `s0_axis_tvalid` / `s1_axis_tvalid`  in  1  source valid.
- `s0_axis_tready` / `s1_axis_tready`  out  1  source ready.
- `m_axis_tdata`  out  DATA_WIDTH  symbols to the decoder.
- `m_axis_tvalid`  out  1  decoder-side valid.
- `m_axis_tready`  in  1  decoder ready.
- `m_axis_tlast`  out  1  marks the final beat of a frame.
- `m_axis_tuser`  out  1  ID of the granted source (0/1).
- `busy`  out  1  high while in XFER.
- `frame_cnt`  out  16  completed frames, both sources combined.

## Operation
- FSM states are IDLE and XFER.
- **IDLE**
  - If `cfg_enable`=1, `cfg_frame_len`≠0 and any source `tvalid`=1: pick the source by round-robin from priority pointer `prio`, register `grant` and `len_q`=`cfg_frame_len`, clear `beat_cnt`, then go to XFER.
  - Otherwise stay in IDLE.
  - If both sources are valid, `grant`=`prio`. If one is valid, grant that one regardless of `prio`.
  - `cfg_frame_len`=0 means no grant is issued.
- **XFER**
  - Combinational pass-through from the granted source: `m_axis_tdata`/`tvalid` follow `s<grant>`, and `s<grant>_axis_tready`=`m_axis_tready`.
  - The non-granted source's `tready` is 0.
  - `m_axis_tlast`=1 when `beat_cnt`==`len_q`-1.
  - `m_axis_tuser`=`grant`.
  - `beat_cnt` increments on each handshake (`m_axis_tvalid & m_axis_tready`).
  - On the handshake of the `tlast` beat: `prio`←~`grant`, `frame_cnt`←`frame_cnt`+1 (wraps 0xFFFF→0x0000), return to IDLE.
- **Boundaries**
  - Source `tlast` inputs do not exist; framing is owned solely by this block.
  - Deasserting `cfg_enable` or changing `cfg_frame_len` mid-frame has no effect until the frame ends.
  - `len_q`=1 gives a single-beat frame with `tlast` on beat 0.
  - A source dropping `tvalid` mid-frame stalls the frame; the grant is held and there is no timeout.
  - `beat_cnt` is LEN_WIDTH wide and never exceeds `len_q`-1.
  - Reset mid-frame aborts it. The partial frame is not counted, and the decoder sees no `tlast`.

## Timing
- Reset values:
  - state=IDLE, `prio`=0, `grant`=0, `beat_cnt`=0, `len_q`=0, `frame_cnt`=0.
  - All `tready`=0, `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tuser`=0, `busy`=0.
- Grant latency: `tvalid` seen in IDLE at cycle N means the first beat can transfer at cycle N+1.
- Every frame is followed by exactly one IDLE bubble cycle. Back-to-back frames of length L therefore take L+1 cycles at full throughput.
- Zero-latency datapath: no registers on `tdata`/`tvalid`/`tready` in XFER.
- `frame_cnt` and `prio` update on the clock edge of the final handshake. `busy` falls on the following cycle.
- Simultaneous requests when `prio`=1 grant source 1 first.

## Structure
- Package `viterbi_sched_pkg` holds:
  - the state enum (`ST_IDLE`, `ST_XFER`);
  - the source-ID localparams (`SRC0`=0, `SRC1`=1);
  - the `frame_cnt` width constant (16).
- Optional sub-module `rr_arb2`: two-request round-robin pick from `prio`, purely combinational.
- All counters and the FSM live in the top module.

## Test plan
- **Single source:** reset, `cfg_frame_len`=4, only s0 streams 0x0001..0x0008 → two frames; `tlast` on 0x0004 and 0x0008; `tuser`=0; `frame_cnt`=2; one idle cycle between frames.
- **Contention:** both sources valid continuously, len=3 → frames alternate s0,s1,s0,s1; `tuser` sequence 0,0,0,1,1,1,…; the non-granted `tready` stays 0.
- **Backpressure:** len=5, `m_axis_tready` toggles every cycle → data order intact; `tlast` only on the 5th handshake; `beat_cnt` does not advance on stalled cycles.
- **Config change mid-frame:** in XFER with len=8, set `cfg_frame_len`=2 and `cfg_enable`=0 at beat 3 → the current frame completes at 8 beats; no new grant follows.
- **Edge lengths:** len=1 → every beat carries `tlast`, and `frame_cnt` increments per beat. len=0 with valid sources → stays IDLE and `tready`=0.
- **Reset mid-frame:** `areset` at beat 2 of len=6 → next cycle all outputs are at reset values, `frame_cnt`=0, and the next grant goes to s0.

Source files
------------

// File: rtl/viterbi_sched_pkg.sv
// Shared types and constants for the Viterbi frame scheduler and its arbiter.
package viterbi_sched_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_XFER = 1'b1
   } state_e;

   localparam logic SRC0 = 1'b0;
   localparam logic SRC1 = 1'b1;

   localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin pick: contention resolves to prio_i, a lone request wins outright.
module rr_arb2
   import viterbi_sched_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       prio_i,
   output logic       gnt_valid_o,
   output logic       gnt_id_o
);

   always_comb begin
      // NOTE: assign a default before any branch so every path drives the output and no latch is inferred.
      gnt_id_o = SRC0;
      if (req_i == 2'b11) begin
         gnt_id_o = prio_i;
      end else if (req_i[1]) begin
         gnt_id_o = SRC1;
      end
   end

   assign gnt_valid_o = |req_i;

endmodule

// File: rtl/viterbi_frame_scheduler.sv
// Frame-granular round-robin scheduler feeding one Viterbi decoder stream from two sources.
module viterbi_frame_scheduler
   import viterbi_sched_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int LEN_WIDTH  = 12
) (
   input  logic                   aclk,
   input  logic                   areset,
   input  logic                   cfg_enable,
   input  logic [LEN_WIDTH-1:0]   cfg_frame_len,
   input  logic [DATA_WIDTH-1:0]  s0_axis_tdata,
   input  logic                   s0_axis_tvalid,
   output logic                   s0_axis_tready,
   input  logic [DATA_WIDTH-1:0]  s1_axis_tdata,
   input  logic                   s1_axis_tvalid,
   output logic                   s1_axis_tready,
   output logic [DATA_WIDTH-1:0]  m_axis_tdata,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic                   m_axis_tlast,
   output logic                   m_axis_tuser,
   output logic                   busy,
   output logic [FRAME_CNT_W-1:0] frame_cnt
);

   state_e                 state_q;
   logic                   prio_q;
   logic                   grant_q;
   logic [LEN_WIDTH-1:0]   beat_cnt_q;
   logic [LEN_WIDTH-1:0]   beat_cnt_d;
   logic [LEN_WIDTH-1:0]   len_q;
   logic [FRAME_CNT_W-1:0] frame_cnt_q;
   logic [FRAME_CNT_W-1:0] frame_cnt_d;

   logic in_xfer;
   logic src_tvalid;
   logic last_beat;
   logic handshake;
   logic arb_valid;
   logic arb_id;
   logic start_frame;

   rr_arb2 u_arb (
      .req_i       ({s1_axis_tvalid, s0_axis_tvalid}),
      .prio_i      (prio_q),
      .gnt_valid_o (arb_valid),
      .gnt_id_o    (arb_id)
   );

   // Datapath is a pure mux on the registered grant, so a beat costs no extra latency.
   assign in_xfer     = (state_q == ST_XFER);
   assign src_tvalid  = (grant_q == SRC1) ? s1_axis_tvalid : s0_axis_tvalid;
   assign last_beat   = (beat_cnt_q == (len_q - LEN_WIDTH'(1)));
   assign handshake   = m_axis_tvalid & m_axis_tready;
   assign start_frame = cfg_enable && (cfg_frame_len != '0) && arb_valid;
   assign beat_cnt_d  = beat_cnt_q + LEN_WIDTH'(1);
   assign frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);

   assign m_axis_tdata   = (grant_q == SRC1) ? s1_axis_tdata : s0_axis_tdata;
   assign m_axis_tvalid  = in_xfer & src_tvalid;
   assign m_axis_tlast   = in_xfer & last_beat;
   assign m_axis_tuser   = in_xfer & grant_q;
   assign s0_axis_tready = in_xfer & (grant_q == SRC0) & m_axis_tready;
   assign s1_axis_tready = in_xfer & (grant_q == SRC1) & m_axis_tready;
   assign busy           = in_xfer;
   assign frame_cnt      = frame_cnt_q;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q     <= ST_IDLE;
         prio_q      <= SRC0;
         grant_q     <= SRC0;
         beat_cnt_q  <= '0;
         len_q       <= '0;
         frame_cnt_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_frame) begin
                  grant_q    <= arb_id;
                  len_q      <= cfg_frame_len;
                  beat_cnt_q <= '0;
                  state_q    <= ST_XFER;
               end
            end
            ST_XFER: begin
               if (handshake) begin
                  if (last_beat) begin
                     prio_q      <= ~grant_q;
                     frame_cnt_q <= frame_cnt_d;
                     beat_cnt_q  <= '0;
                     state_q     <= ST_IDLE;
                  end else begin
                     beat_cnt_q <= beat_cnt_d;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_viterbi_frame_scheduler.sv
// Scoreboard bench: expected beats are queued when source data is loaded and checked on each decoder handshake.
module tb_viterbi_frame_scheduler;

   typedef struct {
      logic [15:0] data;
      logic        last;
      logic        user;
   } exp_t;

   logic        aclk = 1'b0;
   logic        areset = 1'b1;
   logic        cfg_enable = 1'b0;
   logic [11:0] cfg_frame_len = '0;
   logic [15:0] s0_axis_tdata = '0;
   logic        s0_axis_tvalid = 1'b0;
   logic        s0_axis_tready;
   logic [15:0] s1_axis_tdata = '0;
   logic        s1_axis_tvalid = 1'b0;
   logic        s1_axis_tready;
   logic [15:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b1;
   logic        m_axis_tlast;
   logic        m_axis_tuser;
   logic        busy;
   logic [15:0] frame_cnt;

   exp_t        exp_q[$];
   logic [15:0] src0_q[$];
   logic [15:0] src1_q[$];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int m_hs_cnt = 0;
   int first_hs_cyc = -1;
   int last_hs_cyc = -1;
   int rel_cyc = 0;
   bit bp_mode = 1'b0;

   viterbi_frame_scheduler #(.DATA_WIDTH(16), .LEN_WIDTH(12)) dut (
      .aclk           (aclk),
      .areset         (areset),
      .cfg_enable     (cfg_enable),
      .cfg_frame_len  (cfg_frame_len),
      .s0_axis_tdata  (s0_axis_tdata),
      .s0_axis_tvalid (s0_axis_tvalid),
      .s0_axis_tready (s0_axis_tready),
      .s1_axis_tdata  (s1_axis_tdata),
      .s1_axis_tvalid (s1_axis_tvalid),
      .s1_axis_tready (s1_axis_tready),
      .m_axis_tdata   (m_axis_tdata),
      .m_axis_tvalid  (m_axis_tvalid),
      .m_axis_tready  (m_axis_tready),
      .m_axis_tlast   (m_axis_tlast),
      .m_axis_tuser   (m_axis_tuser),
      .busy           (busy),
      .frame_cnt      (frame_cnt)
   );

   always #5 aclk = ~aclk;

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
      end
   endtask

   task automatic push_exp(input logic [15:0] data, input logic last, input logic user);
      exp_t e;
      e.data = data;
      e.last = last;
      e.user = user;
      exp_q.push_back(e);
   endtask

   task automatic drive();
      s0_axis_tvalid = (src0_q.size() > 0);
      s0_axis_tdata  = (src0_q.size() > 0) ? src0_q[0] : 16'h0;
      s1_axis_tvalid = (src1_q.size() > 0);
      s1_axis_tdata  = (src1_q.size() > 0) ? src1_q[0] : 16'h0;
      m_axis_tready  = bp_mode ? ~m_axis_tready : 1'b1;
   endtask

   task automatic cycle();
      exp_t e;
      @(negedge aclk);
      if (!areset) begin
         if (busy)
            check("nongrant_tready", 32'(m_axis_tuser ? s0_axis_tready : s1_axis_tready), 32'd0);
         if (m_axis_tvalid && m_axis_tready) begin
            check("beat_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("tdata", 32'(m_axis_tdata), 32'(e.data));
               check("tlast", 32'(m_axis_tlast), 32'(e.last));
               check("tuser", 32'(m_axis_tuser), 32'(e.user));
            end
            if (first_hs_cyc < 0) first_hs_cyc = cyc;
            last_hs_cyc = cyc;
            m_hs_cnt++;
         end
         if (s0_axis_tvalid && s0_axis_tready) void'(src0_q.pop_front());
         if (s1_axis_tvalid && s1_axis_tready) void'(src1_q.pop_front());
      end
      @(posedge aclk);
      #1;
      cyc++;
      drive();
   endtask

   task automatic run_until_empty(input string tag, input int budget);
      int n = 0;
      while (exp_q.size() > 0 && n < budget) begin
         cycle();
         n++;
      end
      check(tag, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic do_reset();
      areset = 1'b1;
      cfg_enable = 1'b0;
      bp_mode = 1'b0;
      src0_q.delete();
      src1_q.delete();
      exp_q.delete();
      cycle();
      cycle();
      areset = 1'b0;
      m_hs_cnt = 0;
      first_hs_cyc = -1;
      last_hs_cyc = -1;
   endtask

   initial begin
      drive();

      // Reset with traffic already waiting: nothing may leak out while areset is high.
      cfg_enable = 1'b1;
      cfg_frame_len = 12'd4;
      for (int i = 1; i <= 8; i++) begin
         src0_q.push_back(16'(i));
         push_exp(16'(i), (i == 4 || i == 8), 1'b0);
      end
      cycle();
      cycle();
      check("rst_s0_tready", 32'(s0_axis_tready), 32'd0);
      check("rst_s1_tready", 32'(s1_axis_tready), 32'd0);
      check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
      check("rst_m_tlast", 32'(m_axis_tlast), 32'd0);
      check("rst_m_tuser", 32'(m_axis_tuser), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_frame_cnt", 32'(frame_cnt), 32'd0);

      // Single source, two frames of four.
      areset = 1'b0;
      rel_cyc = cyc;
      run_until_empty("single_drain", 50);
      cycle();
      check("single_grant_latency", 32'(first_hs_cyc), 32'(rel_cyc + 1));
      check("single_span", 32'(last_hs_cyc - first_hs_cyc), 32'd8);
      check("single_frame_cnt", 32'(frame_cnt), 32'd2);
      check("single_busy_end", 32'(busy), 32'd0);

      // Contention, len=3: frames alternate s0, s1, s0, s1.
      do_reset();
      for (int i = 0; i < 6; i++) begin
         src0_q.push_back(16'h0100 + 16'(i));
         src1_q.push_back(16'h0200 + 16'(i));
      end
      for (int f = 0; f < 4; f++)
         for (int b = 0; b < 3; b++)
            push_exp(((f % 2) ? 16'h0200 : 16'h0100) + 16'((f / 2) * 3 + b), (b == 2), 1'(f % 2));
      cfg_frame_len = 12'd3;
      cfg_enable = 1'b1;
      drive();
      run_until_empty("contend_drain", 80);
      cycle();
      check("contend_frame_cnt", 32'(frame_cnt), 32'd4);

      // Backpressure, len=5, decoder ready toggling every cycle.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         src0_q.push_back(16'h0300 + 16'(i));
         push_exp(16'h0300 + 16'(i), (i == 4), 1'b0);
      end
      bp_mode = 1'b1;
      cfg_frame_len = 12'd5;
      cfg_enable = 1'b1;
      drive();
      run_until_empty("bp_drain", 60);
      cycle();
      cycle();
      check("bp_frame_cnt", 32'(frame_cnt), 32'd1);

      // Config change mid-frame: current frame still runs 8 beats, no new grant after.
      do_reset();
      for (int i = 0; i < 16; i++) src0_q.push_back(16'h0400 + 16'(i));
      for (int i = 0; i < 8; i++) push_exp(16'h0400 + 16'(i), (i == 7), 1'b0);
      cfg_frame_len = 12'd8;
      cfg_enable = 1'b1;
      drive();
      for (int n = 0; n < 40 && m_hs_cnt < 3; n++) cycle();
      check("cfgchg_reached_beat3", 32'(m_hs_cnt), 32'd3);
      cfg_frame_len = 12'd2;
      cfg_enable = 1'b0;
      run_until_empty("cfgchg_drain", 40);
      for (int n = 0; n < 10; n++) cycle();
      check("cfgchg_frame_cnt", 32'(frame_cnt), 32'd1);
      check("cfgchg_no_regrant", 32'(busy), 32'd0);
      check("cfgchg_src_left", 32'(src0_q.size()), 32'd8);

      // len=1: every beat is a frame, round-robin still applies between single beats.
      do_reset();
      for (int i = 0; i < 4; i++) src0_q.push_back(16'h0500 + 16'(i));
      for (int i = 0; i < 2; i++) src1_q.push_back(16'h0600 + 16'(i));
      push_exp(16'h0500, 1'b1, 1'b0);
      push_exp(16'h0600, 1'b1, 1'b1);
      push_exp(16'h0501, 1'b1, 1'b0);
      push_exp(16'h0601, 1'b1, 1'b1);
      push_exp(16'h0502, 1'b1, 1'b0);
      push_exp(16'h0503, 1'b1, 1'b0);
      cfg_frame_len = 12'd1;
      cfg_enable = 1'b1;
      drive();
      run_until_empty("len1_drain", 40);
      cycle();
      check("len1_frame_cnt", 32'(frame_cnt), 32'd6);

      // len=0 with both sources valid: no grant.
      src0_q.push_back(16'h0AAA);
      src1_q.push_back(16'h0BBB);
      cfg_frame_len = 12'd0;
      drive();
      for (int n = 0; n < 5; n++) cycle();
      check("len0_busy", 32'(busy), 32'd0);
      check("len0_s0_tready", 32'(s0_axis_tready), 32'd0);
      check("len0_s1_tready", 32'(s1_axis_tready), 32'd0);
      check("len0_m_tvalid", 32'(m_axis_tvalid), 32'd0);
      check("len0_frame_cnt", 32'(frame_cnt), 32'd6);

      // Reset mid-frame: abort a len=6 frame after two beats, then prio restarts at s0.
      do_reset();
      src0_q.push_back(16'h0800);
      src0_q.push_back(16'h0801);
      push_exp(16'h0800, 1'b0, 1'b0);
      push_exp(16'h0801, 1'b1, 1'b0);
      cfg_frame_len = 12'd2;
      cfg_enable = 1'b1;
      drive();
      run_until_empty("abort_pre_drain", 30);
      cycle();
      check("abort_pre_frame_cnt", 32'(frame_cnt), 32'd1);
      for (int i = 0; i < 6; i++) src1_q.push_back(16'h0700 + 16'(i));
      push_exp(16'h0700, 1'b0, 1'b1);
      push_exp(16'h0701, 1'b0, 1'b1);
      cfg_frame_len = 12'd6;
      drive();
      for (int n = 0; n < 30 && m_hs_cnt < 4; n++) cycle();
      check("abort_reached_beat2", 32'(m_hs_cnt), 32'd4);
      areset = 1'b1;
      cycle();
      check("abort_s1_tready", 32'(s1_axis_tready), 32'd0);
      check("abort_m_tvalid", 32'(m_axis_tvalid), 32'd0);
      check("abort_m_tlast", 32'(m_axis_tlast), 32'd0);
      check("abort_m_tuser", 32'(m_axis_tuser), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_frame_cnt", 32'(frame_cnt), 32'd0);
      areset = 1'b0;
      src0_q.delete();
      src1_q.delete();
      exp_q.delete();
      src0_q.push_back(16'h0900);
      src1_q.push_back(16'h0901);
      push_exp(16'h0900, 1'b1, 1'b0);
      push_exp(16'h0901, 1'b1, 1'b1);
      cfg_frame_len = 12'd1;
      drive();
      run_until_empty("abort_post_drain", 30);
      cycle();
      check("abort_post_frame_cnt", 32'(frame_cnt), 32'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
